// File: rtl/bomba_pkg.sv
// Shared types and helpers for the multi-channel booster-pump controller.
//   ctrl_state_t : controller FSM states (IDLE, RUN)
//   TRUE / FALSE : 1-bit logic constants
//   onehot()     : channel index -> one-hot pump vector (up to MAX_NCH channels)
package bomba_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } ctrl_state_t;

    localparam logic TRUE    = 1'b1;
    localparam logic FALSE   = 1'b0;
    localparam int   MAX_NCH = 8;

    function automatic logic [MAX_NCH-1:0] onehot(input logic [2:0] idx);
        logic [MAX_NCH-1:0] v;
        v      = '0;
        v[idx] = TRUE;
        return v;
    endfunction

endpackage

// File: rtl/sensor_debounce.sv
// Single-bit sensor debouncer.
// The debounced output follows the raw input only after the raw input has
// disagreed with it for DEB_CYCLES consecutive clock edges.
//   clk    : clock
//   rst_n  : asynchronous active-low reset (output and counter go to 0)
//   i_raw  : raw sensor pin
//   o_deb  : registered debounced value
module sensor_debounce
    import bomba_pkg::*;
#(
    parameter int DEB_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_raw,
    output logic o_deb
);

    localparam int            CW   = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

    logic [CW-1:0] r_cnt;
    logic          r_deb;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of every other flop, independent of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_deb <= FALSE;
        end else if (i_raw == r_deb) begin
            r_cnt <= '0;
        end else if (r_cnt == LAST) begin
            // This edge is the DEB_CYCLES-th consecutive disagreeing sample.
            r_deb <= i_raw;
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_deb = r_deb;

endmodule

// File: rtl/bomba_recalque_multi.sv
// Multi-channel booster-pump controller: one cistern, NCH tanks, NCH pumps,
// at most one pump running. Debounces all sensors, grants round-robin among
// requesting channels, enforces a minimum on-time and latches per-channel
// faults on sensor inconsistency (and, optionally, dry-run timeout).
// Optional feature macro: BOMBA_TIMEOUT_EN enables the dry-run timeout.
// Ports:
//   clk_2              : clock
//   reset_n            : asynchronous active-low reset
//   cisterna_nivel_min : raw cistern sensor, 1 = at/above minimum
//   caixa_nivel_max    : raw per-tank max sensors, 1 = full
//   caixa_nivel_min    : raw per-tank min sensors, 1 = at/above minimum
//   falha_clr          : per-channel fault clear, level-sampled
//   bomba              : pump drive, one-hot or zero (registered)
//   falha              : latched per-channel fault (registered)
//   ativo              : some pump is on (registered)
//   canal              : running or last-granted channel (registered)
module bomba_recalque_multi
    import bomba_pkg::*;
#(
    parameter int NCH        = 2,
    parameter int DEB_CYCLES = 4,
    parameter int MIN_ON     = 8,
    parameter int TIMEOUT    = 64
) (
    input  logic                                   clk_2,
    input  logic                                   reset_n,
    input  logic                                   cisterna_nivel_min,
    input  logic [NCH-1:0]                         caixa_nivel_max,
    input  logic [NCH-1:0]                         caixa_nivel_min,
    input  logic [NCH-1:0]                         falha_clr,
    output logic [NCH-1:0]                         bomba,
    output logic [NCH-1:0]                         falha,
    output logic                                   ativo,
    output logic [((NCH > 1) ? $clog2(NCH) : 1)-1:0] canal
);

    localparam int CW    = (NCH > 1) ? $clog2(NCH) : 1;
    localparam int NSENS = 2 * NCH + 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);
`ifdef BOMBA_TIMEOUT_EN
    localparam int CNT_MAX = TIMEOUT;
`else
    localparam int CNT_MAX = MIN_ON;
`endif
    localparam logic [CNT_W-1:0] MIN_ON_C  = CNT_W'(MIN_ON);
    localparam logic [CNT_W-1:0] CNT_MAX_C = CNT_W'(CNT_MAX);

    // Sensor packing: [NCH-1:0] tank min, [2*NCH-1:NCH] tank max, [2*NCH] cistern.
    logic [NSENS-1:0] w_raw;
    logic [NSENS-1:0] w_deb;
    logic [NCH-1:0]   w_cx_min_d;
    logic [NCH-1:0]   w_cx_max_d;
    logic             w_cist_d;

    assign w_raw = {cisterna_nivel_min, caixa_nivel_max, caixa_nivel_min};

    for (genvar g = 0; g < NSENS; g++) begin : g_deb
        sensor_debounce #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_deb (
            .clk  (clk_2),
            .rst_n(reset_n),
            .i_raw(w_raw[g]),
            .o_deb(w_deb[g])
        );
    end

    assign w_cx_min_d = w_deb[NCH-1:0];
    assign w_cx_max_d = w_deb[2*NCH-1:NCH];
    assign w_cist_d   = w_deb[2*NCH];

    ctrl_state_t      r_state;
    logic [NCH-1:0]   r_bomba;
    logic [NCH-1:0]   r_falha;
    logic             r_ativo;
    logic [CW-1:0]    r_canal;
    logic [CW-1:0]    r_rr_ptr;
    logic [CNT_W-1:0] r_run_cnt;

    logic [NCH-1:0]   w_req;
    logic [NCH-1:0]   w_incons;
    logic [NCH-1:0]   w_falha_set;
    logic [CW-1:0]    w_grant_idx;
    logic [CW-1:0]    w_rr_next;
    logic             w_timeout_hit;
    logic             w_stop;

    assign w_req    = ~w_cx_min_d & {NCH{w_cist_d}} & ~r_falha;
    assign w_incons = w_cx_max_d & ~w_cx_min_d;

`ifdef BOMBA_TIMEOUT_EN
    assign w_timeout_hit = (r_state == RUN) && (r_run_cnt == CNT_MAX_C);
`else
    assign w_timeout_hit = FALSE;
`endif

    // While running, r_bomba is exactly onehot(canal), so it marks the
    // channel a timeout must fault.
    assign w_falha_set = w_incons | (w_timeout_hit ? r_bomba : '0);

    assign w_stop = w_incons[r_canal] || w_timeout_hit || !w_cist_d ||
                    (w_cx_max_d[r_canal] && (r_run_cnt >= MIN_ON_C));

    // Round-robin: scanning offsets from high to low lets the smallest
    // offset from r_rr_ptr win.
    always_comb begin
        int j;
        // NOTE: every combinational output gets a default before any
        // conditional assignment, so no path leaves it unassigned (no latch).
        j           = 0;
        w_grant_idx = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            j = int'(r_rr_ptr) + k;
            if (j >= NCH) j = j - NCH;
            if (w_req[j]) w_grant_idx = CW'(j);
        end
        if (int'(w_grant_idx) == NCH - 1) w_rr_next = '0;
        else                              w_rr_next = w_grant_idx + 1'b1;
    end

    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_bomba   <= '0;
            r_falha   <= '0;
            r_ativo   <= FALSE;
            r_canal   <= '0;
            r_rr_ptr  <= '0;
            r_run_cnt <= '0;
        end else begin
            // Set has priority over clear.
            r_falha <= w_falha_set | (r_falha & ~falha_clr);
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_state   <= RUN;
                        r_canal   <= w_grant_idx;
                        r_bomba   <= NCH'(onehot(3'(w_grant_idx)));
                        r_ativo   <= TRUE;
                        r_rr_ptr  <= w_rr_next;
                        r_run_cnt <= CNT_W'(1);
                    end
                end
                RUN: begin
                    if (w_stop) begin
                        r_state <= IDLE;
                        r_bomba <= '0;
                        r_ativo <= FALSE;
                    end else if (r_run_cnt != CNT_MAX_C) begin
                        r_run_cnt <= r_run_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bomba = r_bomba;
    assign falha = r_falha;
    assign ativo = r_ativo;
    assign canal = r_canal;

endmodule

// File: tb/tb_bomba_recalque_multi.sv
// Scoreboard bench for bomba_recalque_multi (NCH=2, DEB_CYCLES=4, MIN_ON=8,
// TIMEOUT=64). Stimulus pushes expected outputs tagged with the cycle at
// which they must hold; a monitor samples on the falling edge and compares.
module tb_bomba_recalque_multi;

    logic       clk_2   = 1'b0;
    logic       reset_n = 1'b0;
    logic       cist    = 1'b0;
    logic [1:0] cmax    = 2'b00;
    logic [1:0] cmin    = 2'b00;
    logic [1:0] clr     = 2'b00;
    logic [1:0] bomba;
    logic [1:0] falha;
    logic       ativo;
    logic [0:0] canal;

    bomba_recalque_multi #(
        .NCH(2), .DEB_CYCLES(4), .MIN_ON(8), .TIMEOUT(64)
    ) dut (
        .clk_2             (clk_2),
        .reset_n           (reset_n),
        .cisterna_nivel_min(cist),
        .caixa_nivel_max   (cmax),
        .caixa_nivel_min   (cmin),
        .falha_clr         (clr),
        .bomba             (bomba),
        .falha             (falha),
        .ativo             (ativo),
        .canal             (canal)
    );

    always #5 clk_2 = ~clk_2;

    int cyc = 0;
    always @(posedge clk_2) cyc <= cyc + 1;

    typedef struct {
        string      name;
        int         due;
        logic [1:0] bomba;
        logic [1:0] falha;
        logic       ativo;
        logic       canal;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic expect_at(input string name, input int due, input logic [1:0] b,
                             input logic [1:0] f, input logic a, input logic c);
        exp_t e;
        e.name  = name;
        e.due   = due;
        e.bomba = b;
        e.falha = f;
        e.ativo = a;
        e.canal = c;
        sb.push_back(e);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge clk_2);
    endtask

    function automatic logic [1:0] oh(input logic c);
        return c ? 2'b10 : 2'b01;
    endfunction

    // Reset with the given raw sensor levels; returns the release cycle.
    task automatic do_reset(input logic c, input logic [1:0] mx, input logic [1:0] mn,
                            output int base);
        int t;
        @(negedge clk_2);
        reset_n = 1'b0;
        cist    = c;
        cmax    = mx;
        cmin    = mn;
        clr     = 2'b00;
        t       = cyc;
        expect_at("reset_state", t + 1, 2'b00, 2'b00, 1'b0, 1'b0);
        wait_until(t + 2);
        reset_n = 1'b1;
        base    = t + 2;
    endtask

    // Monitor: compare every entry that is due on this falling edge.
    initial begin
        forever begin
            @(negedge clk_2);
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].due == cyc) begin
                    n_cmp++;
                    if (bomba !== sb[i].bomba || falha !== sb[i].falha ||
                        ativo !== sb[i].ativo || canal[0] !== sb[i].canal) begin
                        n_bad++;
                        $display("FAIL %s @cyc %0d: got bomba=%b falha=%b ativo=%b canal=%b, want bomba=%b falha=%b ativo=%b canal=%b",
                                 sb[i].name, cyc, bomba, falha, ativo, canal[0],
                                 sb[i].bomba, sb[i].falha, sb[i].ativo, sb[i].canal);
                    end
                    sb.delete(i);
                end
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   s;
        int   a;
        logic cur;
        logic nxt;

        // Basic fill: channel 0 starts one cycle after cistern debounce,
        // stops 5 edges after its sensors report full.
        do_reset(1'b1, 2'b00, 2'b10, n);
        expect_at("fill_wait",  n + 4,  2'b00, 2'b00, 1'b0, 1'b0);
        expect_at("fill_start", n + 5,  2'b01, 2'b00, 1'b1, 1'b0);
        wait_until(n + 20);
        cmax = 2'b01;
        cmin = 2'b11;
        expect_at("fill_run",   n + 24, 2'b01, 2'b00, 1'b1, 1'b0);
        expect_at("fill_stop",  n + 25, 2'b00, 2'b00, 1'b0, 1'b0);
        expect_at("fill_idle",  n + 28, 2'b00, 2'b00, 1'b0, 1'b0);
        wait_until(n + 29);

        // Debounce reject (3 cycles), then accept (4 cycles).
        do_reset(1'b1, 2'b00, 2'b11, n);
        wait_until(n + 6);
        cmin = 2'b01;
        expect_at("glitch_3_a", n + 10, 2'b00, 2'b00, 1'b0, 1'b0);
        expect_at("glitch_3_b", n + 12, 2'b00, 2'b00, 1'b0, 1'b0);
        wait_until(n + 9);
        cmin = 2'b11;
        wait_until(n + 16);
        cmin = 2'b01;
        expect_at("glitch_4_wait",  n + 20, 2'b00, 2'b00, 1'b0, 1'b0);
        expect_at("glitch_4_start", n + 21, 2'b10, 2'b00, 1'b1, 1'b1);
        wait_until(n + 20);
        cmin = 2'b11;
        wait_until(n + 22);

        // Round-robin: both request, cistern toggled to force stops.
        do_reset(1'b1, 2'b00, 2'b00, n);
        expect_at("rr_start0", n + 5, 2'b01, 2'b00, 1'b1, 1'b0);
        s   = n + 5;
        cur = 1'b0;
        for (int i = 0; i < 3; i++) begin
            nxt = ~cur;
            a   = s + 2;
            wait_until(a);
            cist = 1'b0;
            expect_at("rr_running", a + 4, oh(cur), 2'b00, 1'b1, cur);
            expect_at("rr_stop",    a + 5, 2'b00,   2'b00, 1'b0, cur);
            wait_until(a + 4);
            cist = 1'b1;
            expect_at("rr_grant",   a + 9, oh(nxt), 2'b00, 1'b1, nxt);
            s   = a + 9;
            cur = nxt;
        end
        wait_until(s + 1);

        // Minimum on-time: full is seen 2 cycles after start, run lasts 8.
        do_reset(1'b1, 2'b00, 2'b10, n);
        wait_until(n + 3);
        cmax = 2'b01;
        cmin = 2'b11;
        expect_at("minon_start", n + 5,  2'b01, 2'b00, 1'b1, 1'b0);
        expect_at("minon_full",  n + 7,  2'b01, 2'b00, 1'b1, 1'b0);
        expect_at("minon_last",  n + 12, 2'b01, 2'b00, 1'b1, 1'b0);
        expect_at("minon_stop",  n + 13, 2'b00, 2'b00, 1'b0, 1'b0);
        wait_until(n + 14);

        // Inconsistency on channel 1, clear blocked while inconsistent.
        do_reset(1'b1, 2'b00, 2'b01, n);
        expect_at("inc_start", n + 5, 2'b10, 2'b00, 1'b1, 1'b1);
        wait_until(n + 6);
        cmax = 2'b10;
        expect_at("inc_run",   n + 10, 2'b10, 2'b00, 1'b1, 1'b1);
        expect_at("inc_fault", n + 11, 2'b00, 2'b10, 1'b0, 1'b1);
        wait_until(n + 13);
        clr = 2'b10;
        expect_at("inc_clr_blocked", n + 15, 2'b00, 2'b10, 1'b0, 1'b1);
        wait_until(n + 16);
        clr  = 2'b00;
        cmax = 2'b00;
        expect_at("inc_fixed_held",  n + 20, 2'b00, 2'b10, 1'b0, 1'b1);
        expect_at("inc_before_clr",  n + 22, 2'b00, 2'b10, 1'b0, 1'b1);
        wait_until(n + 22);
        clr = 2'b10;
        expect_at("inc_cleared",     n + 23, 2'b00, 2'b00, 1'b0, 1'b1);
        expect_at("inc_regrant",     n + 24, 2'b10, 2'b00, 1'b1, 1'b1);
        wait_until(n + 23);
        clr = 2'b00;
        wait_until(n + 25);

        // Dry-run timeout on channel 0.
        do_reset(1'b1, 2'b00, 2'b10, n);
        expect_at("to_start", n + 5,  2'b01, 2'b00, 1'b1, 1'b0);
        expect_at("to_last",  n + 68, 2'b01, 2'b00, 1'b1, 1'b0);
`ifdef BOMBA_TIMEOUT_EN
        expect_at("to_fault", n + 69, 2'b00, 2'b01, 1'b0, 1'b0);
        expect_at("to_held",  n + 72, 2'b00, 2'b01, 1'b0, 1'b0);
`else
        expect_at("to_none",  n + 69, 2'b01, 2'b00, 1'b1, 1'b0);
        expect_at("to_held",  n + 72, 2'b01, 2'b00, 1'b1, 1'b0);
`endif
        wait_until(n + 73);

        // Reset asserted mid-run on channel 1 drops outputs asynchronously.
        do_reset(1'b1, 2'b00, 2'b01, n);
        expect_at("rst_run_start", n + 5,  2'b10, 2'b00, 1'b1, 1'b1);
        expect_at("rst_run_pre",   n + 10, 2'b10, 2'b00, 1'b1, 1'b1);
        expect_at("rst_async",     n + 11, 2'b00, 2'b00, 1'b0, 1'b0);
        expect_at("rst_held",      n + 13, 2'b00, 2'b00, 1'b0, 1'b0);
        wait_until(n + 10);
        @(posedge clk_2);
        #2;
        reset_n = 1'b0;
        wait_until(n + 14);
        reset_n = 1'b1;
        wait_until(n + 15);

        if (sb.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
